// File: rtl/cg_seq_if.sv
// rtl/cg_seq_if.sv - arm/fire controls and per-stage core signals seen by the coil-gun sequencer
interface cg_seq_if #(
  parameter int N_STG = 4
);
  logic             I_ARM;
  logic             I_FIRE;
  logic             I_ABORT;
  logic [N_STG-1:0] I_SOE;
  logic [N_STG-1:0] I_RTE;
  logic             O_EN;
  logic [N_STG-1:0] O_TRIG;
  logic             O_CRST;
  logic [3:0]       O_STG;
  logic             O_BUSY;
  logic             O_DONE;
  logic             O_FLT;
  logic [2:0]       O_FCODE;

  modport master (
    input  I_ARM, I_FIRE, I_ABORT, I_SOE, I_RTE,
    output O_EN, O_TRIG, O_CRST, O_STG, O_BUSY, O_DONE, O_FLT, O_FCODE
  );

  modport slave (
    output I_ARM, I_FIRE, I_ABORT, I_SOE, I_RTE,
    input  O_EN, O_TRIG, O_CRST, O_STG, O_BUSY, O_DONE, O_FLT, O_FCODE
  );
endinterface

// File: rtl/cg_seq.sv
// rtl/cg_seq.sv - multi-stage firing sequencer: trigger each stage, wait for engage and release, supervise faults
module cg_seq #(
  parameter int N_STG  = 4,
  parameter int TW     = 24,
  parameter int ACK_TO = 16,
  parameter int RUN_TO = 1048576
) (
  input  logic     clk,
  input  logic     I_RST,
  cg_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_TRIG, S_WACK, S_RUN, S_NEXT, S_CLR, S_FAULT
  } state_t;

  localparam logic [TW-1:0] ACK_LIM  = TW'(ACK_TO - 1);
  localparam logic [TW-1:0] RUN_LIM  = TW'(RUN_TO - 1);
  localparam logic [3:0]    LAST_IDX = 4'(N_STG - 1);

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            fire_q, fire_d;
  logic [2:0]      fcode_q, fcode_d;
  logic            flt_first_q, flt_first_d;

  logic [N_STG-1:0] stg_mask;
  logic             soe_own, xfire, rte_own, abort, fire_edge, last;

  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      fire_q      <= 1'b0;
      fcode_q     <= '0;
      flt_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      fire_q      <= fire_d;
      fcode_q     <= fcode_d;
      flt_first_q <= flt_first_d;
    end
  end

  always_comb begin
    stg_mask  = N_STG'(1) << idx_q;
    soe_own   = |(bus.I_SOE & stg_mask);
    xfire     = |(bus.I_SOE & ~stg_mask);
    rte_own   = |(bus.I_RTE & stg_mask);
    abort     = bus.I_ABORT | ~bus.I_ARM;
    fire_edge = bus.I_FIRE & ~fire_q;
    last      = (idx_q == LAST_IDX);

    state_d = state_q;
    idx_d   = idx_q;
    fcode_d = fcode_q;
    fire_d  = bus.I_FIRE;

    case (state_q)
      S_IDLE: begin
        if (bus.I_ARM) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!bus.I_ARM) begin
          state_d = S_IDLE;
        end else if (fire_edge && !bus.I_ABORT) begin
          state_d = S_TRIG;
          idx_d   = '0;
        end
      end
      S_TRIG: begin
        state_d = abort ? S_CLR : S_WACK;
      end
      // Cross-fire outranks abort; abort outranks acknowledge and timeout.
      S_WACK: begin
        if (xfire) begin
          state_d = S_FAULT;
          fcode_d = 3'd5;
        end else if (abort) begin
          state_d = S_CLR;
        end else if (soe_own) begin
          state_d = S_RUN;
        end else if (timer_q == ACK_LIM) begin
          state_d = S_FAULT;
          fcode_d = 3'd1;
        end
      end
      S_RUN: begin
        if (rte_own) begin
          state_d = S_FAULT;
          fcode_d = 3'd2;
        end else if (xfire) begin
          state_d = S_FAULT;
          fcode_d = 3'd5;
        end else if (abort) begin
          state_d = S_CLR;
        end else if (!soe_own) begin
          state_d = S_NEXT;
        end else if (timer_q == RUN_LIM) begin
          state_d = S_FAULT;
          fcode_d = 3'd3;
        end
      end
      S_NEXT: begin
        if (abort || last) begin
          state_d = S_CLR;
        end else begin
          state_d = S_TRIG;
          idx_d   = idx_q + 4'd1;
        end
      end
      S_CLR: begin
        idx_d   = '0;
        state_d = bus.I_ARM ? S_ARMED : S_IDLE;
      end
      S_FAULT: begin
        if (!bus.I_ARM) begin
          state_d = S_IDLE;
          fcode_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if ((state_q == S_WACK || state_q == S_RUN) && timer_q != '1) begin
      timer_d = timer_q + 1'b1;
    end

    flt_first_d = (state_d == S_FAULT) && (state_q != S_FAULT);
  end

  assign bus.O_EN    = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign bus.O_TRIG  = (state_q == S_TRIG) ? stg_mask : '0;
  assign bus.O_CRST  = (state_q == S_CLR) || (state_q == S_FAULT && flt_first_q);
  assign bus.O_STG   = idx_q;
  assign bus.O_BUSY  = (state_q == S_TRIG) || (state_q == S_WACK) ||
                       (state_q == S_RUN)  || (state_q == S_NEXT);
  assign bus.O_DONE  = (state_q == S_NEXT) && last && !abort;
  assign bus.O_FLT   = (state_q == S_FAULT);
  assign bus.O_FCODE = fcode_q;

endmodule

// File: tb/tb_cg_seq.sv
// tb/tb_cg_seq.sv - directed bench for cg_seq built with RUN_TO=100
module tb_cg_seq;
  localparam int N = 4;

  logic clk;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  cg_seq_if #(.N_STG(N)) bus ();

  cg_seq #(.N_STG(N), .TW(24), .ACK_TO(16), .RUN_TO(100)) dut (
    .clk   (clk),
    .I_RST (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fire_shot();
    bus.I_FIRE = 1'b0;
    cyc();
    bus.I_FIRE = 1'b1;
    cyc();
    chk("trig0", 32'(bus.O_TRIG), 32'h1);
    chk("trig0_stg", 32'(bus.O_STG), 32'h0);
    chk("trig0_busy", 32'(bus.O_BUSY), 32'h1);
  endtask

  // Stage model: I_SOE rises 3 cycles after its trigger and falls 20 cycles later.
  task automatic stage_nominal(input int s);
    cyc();
    chk("wack_trig", 32'(bus.O_TRIG), 32'h0);
    cyc();
    cyc();
    bus.I_SOE[s] = 1'b1;
    repeat (20) cyc();
    bus.I_SOE[s] = 1'b0;
    #1;
    chk("run_busy", 32'(bus.O_BUSY), 32'h1);
    cyc();
    chk("next_done", 32'(bus.O_DONE), (s == N - 1) ? 32'h1 : 32'h0);
    chk("next_trig", 32'(bus.O_TRIG), 32'h0);
    cyc();
    if (s < N - 1) begin
      chk("next_stage_trig", 32'(bus.O_TRIG), 32'h1 << (s + 1));
      chk("next_stage_stg", 32'(bus.O_STG), 32'(s + 1));
    end else begin
      chk("clr_crst", 32'(bus.O_CRST), 32'h1);
      chk("clr_done", 32'(bus.O_DONE), 32'h0);
      cyc();
      chk("armed_stg", 32'(bus.O_STG), 32'h0);
      chk("armed_busy", 32'(bus.O_BUSY), 32'h0);
      chk("armed_en", 32'(bus.O_EN), 32'h1);
      chk("armed_crst", 32'(bus.O_CRST), 32'h0);
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.I_ARM   = 1'b0;
    bus.I_FIRE  = 1'b1;
    bus.I_ABORT = 1'b0;
    bus.I_SOE   = '0;
    bus.I_RTE   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {bus.O_EN, bus.O_TRIG, bus.O_CRST, bus.O_STG, bus.O_BUSY,
                       bus.O_DONE, bus.O_FLT, bus.O_FCODE}, 32'h0);

    // Fire held high out of reset and through arming must not start a shot.
    rst = 1'b0;
    cyc();
    chk("idle_en", 32'(bus.O_EN), 32'h0);
    bus.I_ARM = 1'b1;
    cyc();
    chk("armed_en0", 32'(bus.O_EN), 32'h1);
    repeat (3) cyc();
    chk("held_fire_busy", 32'(bus.O_BUSY), 32'h0);
    chk("held_fire_trig", 32'(bus.O_TRIG), 32'h0);

    // Nominal shot through all stages.
    fire_shot();
    for (int s = 0; s < N; s++) stage_nominal(s);

    // Stage 1 never acknowledges.
    fire_shot();
    stage_nominal(0);
    repeat (16) cyc();
    chk("noack_pre_flt", 32'(bus.O_FLT), 32'h0);
    cyc();
    chk("noack_flt", 32'(bus.O_FLT), 32'h1);
    chk("noack_code", 32'(bus.O_FCODE), 32'h1);
    chk("noack_stg", 32'(bus.O_STG), 32'h1);
    chk("noack_en", 32'(bus.O_EN), 32'h0);
    chk("noack_crst", 32'(bus.O_CRST), 32'h1);
    chk("noack_busy", 32'(bus.O_BUSY), 32'h0);
    cyc();
    chk("noack_crst_once", 32'(bus.O_CRST), 32'h0);
    chk("noack_code_hold", 32'(bus.O_FCODE), 32'h1);
    bus.I_FIRE = 1'b0;
    cyc();
    bus.I_FIRE = 1'b1;
    cyc();
    chk("fault_fire_ignored", 32'(bus.O_FLT), 32'h1);
    chk("fault_fire_trig", 32'(bus.O_TRIG), 32'h0);
    bus.I_ARM = 1'b0;
    cyc();
    chk("fault_exit_flt", 32'(bus.O_FLT), 32'h0);
    chk("fault_exit_code", 32'(bus.O_FCODE), 32'h0);
    chk("fault_exit_en", 32'(bus.O_EN), 32'h0);

    // Runtime limit: RUN cycle 100 faults with code 3.
    bus.I_ARM = 1'b1;
    cyc();
    fire_shot();
    cyc();
    bus.I_SOE[0] = 1'b1;
    repeat (100) cyc();
    chk("rto_pre_flt", 32'(bus.O_FLT), 32'h0);
    cyc();
    chk("rto_flt", 32'(bus.O_FLT), 32'h1);
    chk("rto_code", 32'(bus.O_FCODE), 32'h3);
    bus.I_SOE = '0;
    bus.I_ARM = 1'b0;
    cyc();
    chk("rto_exit_code", 32'(bus.O_FCODE), 32'h0);

    // RTE together with the I_SOE fall wins over advancing.
    bus.I_ARM = 1'b1;
    cyc();
    fire_shot();
    cyc();
    bus.I_SOE[0] = 1'b1;
    repeat (3) cyc();
    bus.I_SOE[0] = 1'b0;
    bus.I_RTE[0] = 1'b1;
    cyc();
    chk("rte_code", 32'(bus.O_FCODE), 32'h2);
    chk("rte_stg", 32'(bus.O_STG), 32'h0);
    bus.I_RTE = '0;
    bus.I_ARM = 1'b0;
    cyc();

    // Cross-fire from stage 2 while stage 0 runs.
    bus.I_ARM = 1'b1;
    cyc();
    fire_shot();
    cyc();
    bus.I_SOE[0] = 1'b1;
    repeat (2) cyc();
    bus.I_SOE = 4'b0101;
    cyc();
    chk("xfire_code", 32'(bus.O_FCODE), 32'h5);
    bus.I_SOE = '0;
    bus.I_ARM = 1'b0;
    cyc();

    // Cross-fire and abort in the same cycle: the fault wins.
    bus.I_ARM = 1'b1;
    cyc();
    fire_shot();
    cyc();
    bus.I_SOE[0] = 1'b1;
    repeat (2) cyc();
    bus.I_SOE   = 4'b0101;
    bus.I_ABORT = 1'b1;
    cyc();
    chk("xfire_abort_flt", 32'(bus.O_FLT), 32'h1);
    chk("xfire_abort_code", 32'(bus.O_FCODE), 32'h5);
    bus.I_ABORT = 1'b0;
    bus.I_SOE   = '0;
    bus.I_ARM   = 1'b0;
    cyc();

    // Abort during stage-2 RUN.
    bus.I_ARM = 1'b1;
    cyc();
    fire_shot();
    stage_nominal(0);
    stage_nominal(1);
    cyc();
    bus.I_SOE[2] = 1'b1;
    repeat (2) cyc();
    bus.I_ABORT = 1'b1;
    #1;
    chk("abort_run_done", 32'(bus.O_DONE), 32'h0);
    cyc();
    chk("abort_clr_crst", 32'(bus.O_CRST), 32'h1);
    chk("abort_clr_done", 32'(bus.O_DONE), 32'h0);
    chk("abort_clr_busy", 32'(bus.O_BUSY), 32'h0);
    chk("abort_clr_en", 32'(bus.O_EN), 32'h1);
    bus.I_ABORT = 1'b0;
    bus.I_SOE   = '0;
    cyc();
    chk("abort_armed_en", 32'(bus.O_EN), 32'h1);
    chk("abort_armed_stg", 32'(bus.O_STG), 32'h0);
    chk("abort_armed_crst", 32'(bus.O_CRST), 32'h0);

    // Disarm during WACK: CLR then IDLE.
    fire_shot();
    cyc();
    bus.I_ARM = 1'b0;
    cyc();
    chk("disarm_clr_crst", 32'(bus.O_CRST), 32'h1);
    cyc();
    chk("disarm_idle_en", 32'(bus.O_EN), 32'h0);
    chk("disarm_idle_crst", 32'(bus.O_CRST), 32'h0);

    // Reset mid-RUN clears outputs asynchronously.
    bus.I_ARM = 1'b1;
    cyc();
    fire_shot();
    cyc();
    bus.I_SOE[0] = 1'b1;
    cyc();
    chk("prerst_busy", 32'(bus.O_BUSY), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_outs", {bus.O_EN, bus.O_TRIG, bus.O_CRST, bus.O_STG, bus.O_BUSY,
                           bus.O_DONE, bus.O_FLT, bus.O_FCODE}, 32'h0);
    bus.I_SOE = '0;
    bus.I_ARM = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    chk("post_rst_en", 32'(bus.O_EN), 32'h0);
    chk("post_rst_busy", 32'(bus.O_BUSY), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/cg_seq.md
Name: cg_seq

Overview:
- Multi-stage firing sequencer that drives N_STG cg_core stage instances in order.
- Issues one trigger pulse per stage and waits for that stage's solenoid to engage and then release before advancing.
- Supervises acknowledge time, per-stage runtime, runtime-exceeded flags and cross-stage misfires.
- Sits between the operator/CREG arm and fire controls and the per-stage core array; owns the cores' enable and reset lines.

Parameters:
N_STG, 4, number of coil stages sequenced (2..16)
TW, 24, width of the internal cycle timer
ACK_TO, 16, cycles allowed from trigger to I_SOE[idx] rising
RUN_TO, 1048576, max cycles a stage may hold I_SOE high (must be < 2^TW)

Ports:
clk  in  1  system clock, all logic on rising edge
I_RST  in  1  asynchronous, active-high reset
I_ARM  in  1  level; arm request
I_FIRE  in  1  fire command; rising edge starts a shot
I_ABORT  in  1  level; abort current shot
I_SOE  in  N_STG  per-stage solenoid-enable feedback (core O_SOE)
I_RTE  in  N_STG  per-stage runtime-exceeded flags (core O_RTE)
O_EN  out  1  logic enable to all cores (core I_EN)
O_TRIG  out  N_STG  one-hot, single-cycle trigger pulse to stage idx
O_CRST  out  1  single-cycle reset pulse to all cores (core I_RST)
O_STG  out  4  current stage index idx
O_BUSY  out  1  high in TRIG, WACK, RUN, NEXT
O_DONE  out  1  single-cycle pulse when last stage completes
O_FLT  out  1  high while in FAULT
O_FCODE  out  3  fault cause; holds its value in FAULT, 0 otherwise

Behaviour:
- Reset (async assert, sync release): state=IDLE, idx=0, timer=0, fire-edge register=0; all outputs 0.
- Fire edge detection: the previous value of I_FIRE is registered; an edge is detected when the prior value is 0 and the current value is 1. A fire input already held high out of reset does not fire.
- Timer: TW-bit counter, cleared on every state change, increments every cycle in WACK and RUN, saturates at all-ones.
- IDLE: O_EN=0. I_ARM=1 -> ARMED.
- ARMED: O_EN=1.
  - I_ARM=0 -> IDLE.
  - Fire edge with I_ABORT=0 -> TRIG, idx=0.
- TRIG (1 cycle): O_TRIG[idx]=1, then -> WACK.
- WACK, evaluated in priority order:
  - cross-fire: I_SOE[j]=1 for any j!=idx -> FAULT, code 5.
  - I_SOE[idx]=1 -> RUN.
  - timer==ACK_TO-1 -> FAULT, code 1 (no acknowledge).
- RUN, evaluated in priority order:
  - I_RTE[idx]=1 -> FAULT, code 2.
  - cross-fire -> FAULT, code 5.
  - I_SOE[idx]=0 -> NEXT.
  - timer==RUN_TO-1 -> FAULT, code 3.
- NEXT (1 cycle):
  - idx==N_STG-1 -> O_DONE=1, go to CLR.
  - otherwise idx<=idx+1 and go to TRIG, giving 1 dead cycle between a stage's I_SOE fall and the next trigger.
- CLR (1 cycle): O_CRST=1, idx<=0. Next state is ARMED if I_ARM=1, else IDLE.
- Abort: I_ABORT=1 or I_ARM=0 in TRIG, WACK, RUN or NEXT -> CLR.
  - No O_DONE is issued.
  - Abort outranks every transition above except an RTE or cross-fire fault detected in the same cycle.
- FAULT:
  - O_EN=0, O_FLT=1, O_FCODE held.
  - O_CRST=1 on the first FAULT cycle only.
  - Exit only when I_ARM=0 -> IDLE; O_FCODE is cleared on exit.
  - Fire edges are ignored while in FAULT.
- O_EN is 1 in ARMED, TRIG, WACK, RUN, NEXT and CLR; it is 0 in IDLE and FAULT.
- O_TRIG is never multi-hot and never asserted outside TRIG.
- O_STG reflects idx in all states.
- Reset asserted mid-shot: all outputs drop to 0 immediately, combinationally through the async clear. No O_CRST pulse is generated; the system reset also resets the cores.

Test Plan:
- Nominal 4-stage shot: arm, pulse fire; each stage model raises I_SOE 3 cycles after its O_TRIG and drops it 20 cycles later -> O_TRIG pulses in order 0,1,2,3; O_DONE 1 cycle after the stage-3 I_SOE fall; O_CRST the cycle after that; return to ARMED.
- No acknowledge: stage 1 never raises I_SOE -> FAULT after exactly 16 WACK cycles; O_FCODE=1; O_STG=1; O_EN=0; single O_CRST pulse; I_ARM=0 returns to IDLE with O_FCODE=0.
- Runtime: stage 0 holds I_SOE; bench built with RUN_TO=100 -> FAULT code 3 on RUN cycle 100. Separately, I_RTE[0]=1 on the same cycle as the I_SOE fall -> code 2, no advance to stage 1.
- Cross-fire: I_SOE[2] rises while idx=0 is in RUN -> FAULT code 5. Also check abort=1 asserted together with cross-fire -> FAULT wins.
- Abort and disarm: I_ABORT=1 during stage-2 RUN -> CLR; O_CRST pulse; no O_DONE; back to ARMED. Dropping I_ARM during WACK -> CLR then IDLE.
- Edge and reset cases: I_FIRE held high out of reset and through arming -> no shot until I_FIRE falls and rises again. I_RST asserted mid-RUN -> all outputs 0 asynchronously; state IDLE after release.
